dmux4way_stream: RTL
====================

DMUX4WAY_STREAM -- requirements
Module: dmux4way_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_data  input  WIDTH  word to route.
REQ-005 SHALL have port in_sel  input  2  destination lane 0..3, qualified by in_valid.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data/in_sel.
REQ-007 SHALL have port in_ready  output  1  block accepts this cycle.
REQ-008 SHALL have port out_data  output  4*WIDTH  lane k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port out_valid  output  4  lane k holds a word.
REQ-010 SHALL have port out_ready  input  4  consumer k takes lane k word.

Function
REQ-011 SHALL hold one 1-entry buffer per lane: data register plus valid flag.
REQ-012 SHALL drive in_ready = ~valid[in_sel] | out_ready[in_sel], combinational, independent of in_valid.
REQ-013 SHALL accept a word when in_valid & in_ready, loading buffer in_sel at that edge; out_valid[in_sel] rises the next cycle (latency 1).
REQ-014 SHALL complete lane k output transfer when out_valid[k] & out_ready[k], clearing valid[k] unless reloaded in the same cycle.
REQ-015 SHALL, on simultaneous drain and accept of the same lane, keep valid[k]=1 with the new word, sustaining 1 word/cycle per lane.
REQ-016 SHALL hold out_data lane k stable while out_valid[k] & ~out_ready[k].
REQ-017 SHALL leave lanes other than in_sel unchanged on accept; their drains proceed independently in the same cycle.
REQ-018 SHALL retain last data in an empty lane (out_valid[k]=0); consumers ignore it.
REQ-019 SHALL not stall other lanes when one lane is full and blocked (no head-of-line blocking beyond the current input word).
REQ-020 SHALL ignore in_data/in_sel when in_valid=0; no state change.

Reset
REQ-021 SHALL, on reset assertion, asynchronously clear out_valid to 4'b0000 and all lane data to 0.
REQ-022 SHALL discard any word in flight on reset mid-operation; no handshake completes in a cycle where reset is high.
REQ-023 SHALL resume accepting on the first rising clk edge after reset deasserts (in_ready=1 for every in_sel).

Configuration
REQ-024 SHALL, with DMUX4WAY_STREAM_CNT_EN defined, add port out_cnt  output  32, lane k 8-bit transfer count at bits [k*8 +: 8], incremented per completed output handshake, wrapping 255->0, reset to 0.
REQ-025 SHALL, without DMUX4WAY_STREAM_CNT_EN, omit out_cnt and all counter logic; routing behaviour identical.

Structure
REQ-026 SHALL place constants LANES=4, SEL_W=2, CNT_W=8 and default WIDTH=16 in shared package dmux4way_pkg.
REQ-027 SHALL implement the per-lane buffer (load, drain, valid, optional counter) as sub-module dmux_lane, instantiated 4 times.

Verification
REQ-028 Reset then in_sel=2, in_data=16'hBEEF, valid 1 cycle, out_ready=4'b0100 -> out_valid=4'b0100, lane2 data 16'hBEEF one cycle later, cleared next cycle.
REQ-029 Lane 1 full, out_ready[1]=0, in_sel=1 -> in_ready=0; switch in_sel=3 -> in_ready=1, word lands in lane 3, lane 1 data unchanged.
REQ-030 Lane 0 full, out_ready[0]=1, in_sel=0 every cycle with 16'h0001..16'h0004 -> 4 words out in order, one per cycle, in_ready stays 1.
REQ-031 Assert reset while lanes 0 and 2 full -> out_valid=4'b0000, data 0 immediately; first post-reset word accepted.
REQ-032 With DMUX4WAY_STREAM_CNT_EN, 257 transfers on lane 3 -> out_cnt[31:24]=8'd1, other lanes 0.

Source files
------------

// File: rtl/dmux4way_stream_pkg.sv
// Shared constants for the 4-way stream demultiplexer.
//   LANES         : number of output lanes
//   SEL_W         : width of the lane select
//   CNT_W         : width of each per-lane transfer counter (optional feature)
//   DEFAULT_WIDTH : default data word width
package dmux4way_pkg;
  localparam int unsigned LANES         = 4;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned DEFAULT_WIDTH = 16;
endpackage

// File: rtl/dmux4way_stream_if.sv
// Stream bundle for dmux4way_stream.
//   in_data/in_sel/in_valid -> in_ready : producer side handshake
//   out_data/out_valid <- out_ready     : four consumer lanes, lane k at
//                                         out_data[k*WIDTH +: WIDTH]
//   out_cnt                             : per-lane 8-bit transfer counts, only
//                                         with DMUX4WAY_STREAM_CNT_EN defined
// Modports: slave = the demux block, master = producer/consumer environment.
interface dmux4way_stream_if
  import dmux4way_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
`ifdef DMUX4WAY_STREAM_CNT_EN
  logic [LANES*CNT_W-1:0] out_cnt;
`endif

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
`ifdef DMUX4WAY_STREAM_CNT_EN
    output out_cnt,
`endif
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
`ifdef DMUX4WAY_STREAM_CNT_EN
    input  out_cnt,
`endif
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dmux4way_stream_lane.sv
// dmux_lane: one-entry output buffer for a single demux lane.
//   clk, reset : clock, asynchronous active-high reset
//   load_i     : write data_i into the buffer this edge
//   data_i     : incoming word
//   ready_i    : consumer takes the buffered word this cycle
//   valid_o    : buffer holds a word
//   data_o     : buffered word (last value retained when empty)
//   cnt_o      : completed output transfers, wrapping (DMUX4WAY_STREAM_CNT_EN)
module dmux_lane
  import dmux4way_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
`ifdef DMUX4WAY_STREAM_CNT_EN
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain = valid_q & ready_i;

  // A load in the same cycle as a drain keeps the lane full with the new word.
  always_comb begin
    valid_d = valid_q & ~drain;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef DMUX4WAY_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif
endmodule

// File: rtl/dmux4way_stream.sv
// dmux4way_stream: routes one input word per cycle to one of four buffered
// output lanes selected by in_sel. Each lane drains independently, so a
// blocked lane only stalls words addressed to it.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : dmux4way_stream_if slave (in_* handshake, out_* lanes)
// Optional: DMUX4WAY_STREAM_CNT_EN adds per-lane transfer counters (bus.out_cnt).
module dmux4way_stream
  import dmux4way_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  dmux4way_stream_if.slave  bus
);
  logic [LANES-1:0]       valid_w;
  logic [LANES-1:0]       load_w;
  logic [LANES*WIDTH-1:0] data_w;
  logic                   accept;
`ifdef DMUX4WAY_STREAM_CNT_EN
  logic [LANES*CNT_W-1:0] cnt_w;
`endif

  // Ready depends only on the addressed lane, never on in_valid.
  assign bus.in_ready = ~valid_w[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load_w = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      load_w[i] = accept && (bus.in_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dmux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load_i (load_w[g]),
      .data_i (bus.in_data),
      .ready_i(bus.out_ready[g]),
      .valid_o(valid_w[g]),
`ifdef DMUX4WAY_STREAM_CNT_EN
      .cnt_o  (cnt_w[g*CNT_W +: CNT_W]),
`endif
      .data_o (data_w[g*WIDTH +: WIDTH])
    );
  end

  assign bus.out_valid = valid_w;
  assign bus.out_data  = data_w;
`ifdef DMUX4WAY_STREAM_CNT_EN
  assign bus.out_cnt   = cnt_w;
`endif
endmodule
